// File: rtl/vshift_operand_stage_if.sv
// Handshake and operand bus between the request source, the operand stage and the vector shifters.
// The stage uses the slave view; the producer/consumer side uses the master view.
interface vshift_operand_stage_if #(
    parameter int DATA_W = 128,
    parameter int XLEN   = 64,
    parameter int IMM_W  = 5
);
    logic              flush_i;
    logic              valid_i;
    logic              ready_o;
    logic [2:0]        vsew_i;
    logic [1:0]        op_i;
    logic [1:0]        src_sel_i;
    logic [DATA_W-1:0] vs2_i;
    logic [DATA_W-1:0] vs1_i;
    logic [XLEN-1:0]   rs1_i;
    logic [IMM_W-1:0]  imm_i;
    logic              valid_o;
    logic              ready_i;
    logic [2:0]        vsew_o;
    logic [1:0]        op_o;
    logic [DATA_W-1:0] a_o;
    logic [DATA_W-1:0] b_o;
    logic              err_o;

    modport slave (
        input  flush_i, valid_i, vsew_i, op_i, src_sel_i, vs2_i, vs1_i, rs1_i, imm_i, ready_i,
        output ready_o, valid_o, vsew_o, op_o, a_o, b_o, err_o
    );

    modport master (
        output flush_i, valid_i, vsew_i, op_i, src_sel_i, vs2_i, vs1_i, rs1_i, imm_i, ready_i,
        input  ready_o, valid_o, vsew_o, op_o, a_o, b_o, err_o
    );
endinterface

// File: rtl/vshift_operand_stage.sv
// Shift-operand formatter: selects and broadcasts the shift amount, masks it to log2(SEW) bits,
// and hands a/b/vsew/op to the shifters through a 2-entry skid buffer with a registered ready.
module vshift_operand_stage #(
    parameter int DATA_W = 128,
    parameter int XLEN   = 64,
    parameter int IMM_W  = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    vshift_operand_stage_if.slave   bus
);
    typedef struct packed {
        logic              err;
        logic [2:0]        vsew;
        logic [1:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state_reg;
    entry_t main_reg;
    entry_t skid_reg;
    logic   ready_reg;

    logic [63:0]              rs1_z;
    logic [63:0]              imm_z;
    logic [3:0][DATA_W-1:0]   b_sew;
    logic                     err_in;
    entry_t                   in_entry;
    logic                     push;
    logic                     pop;

    assign rs1_z = 64'(bus.rs1_i[XLEN-1:0]);
    assign imm_z = {{(64-IMM_W){1'b0}}, bus.imm_i};

    // One candidate amount vector per legal SEW; each lane keeps only its low log2(SEW) bits.
    genvar gw, gi;
    generate
        for (gw = 0; gw < 4; gw++) begin : g_sew
            localparam int W = 8 << gw;
            for (gi = 0; gi < DATA_W / W; gi++) begin : g_lane
                logic [W-1:0] lane;
                assign lane = (bus.src_sel_i == 2'b00) ? bus.vs1_i[gi*W +: W] :
                              (bus.src_sel_i == 2'b01) ? rs1_z[W-1:0] : imm_z[W-1:0];
                assign b_sew[gw][gi*W +: W] = lane & W'(W - 1);
            end
        end
    endgenerate

    assign err_in = bus.vsew_i[2] | (bus.src_sel_i == 2'b11);

    always_comb begin
        in_entry      = '0;
        in_entry.err  = err_in;
        in_entry.vsew = bus.vsew_i;
        in_entry.op   = bus.op_i;
        in_entry.a    = bus.vs2_i;
        in_entry.b    = err_in ? '0 : b_sew[bus.vsew_i[1:0]];
    end

    assign push = bus.valid_i && ready_reg;
    assign pop  = (state_reg != EMPTY) && bus.ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= EMPTY;
            ready_reg <= 1'b1;
            main_reg  <= '0;
            skid_reg  <= '0;
        end else if (bus.flush_i) begin
            state_reg <= EMPTY;
            ready_reg <= 1'b1;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (push) begin
                        main_reg  <= in_entry;
                        state_reg <= ONE;
                    end
                    ready_reg <= 1'b1;
                end
                ONE: begin
                    if (push && !pop) begin
                        skid_reg  <= in_entry;
                        state_reg <= FULL;
                        ready_reg <= 1'b0;
                    end else if (push && pop) begin
                        main_reg  <= in_entry;
                        ready_reg <= 1'b1;
                    end else if (pop) begin
                        state_reg <= EMPTY;
                        ready_reg <= 1'b1;
                    end
                end
                FULL: begin
                    // ready is low here, so only the drain path exists
                    if (pop) begin
                        main_reg  <= skid_reg;
                        state_reg <= ONE;
                        ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= EMPTY;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready_o = ready_reg;
    assign bus.valid_o = (state_reg != EMPTY);
    assign bus.err_o   = main_reg.err;
    assign bus.vsew_o  = main_reg.vsew;
    assign bus.op_o    = main_reg.op;
    assign bus.a_o     = main_reg.a;
    assign bus.b_o     = main_reg.b;
endmodule

// File: tb/tb_vshift_operand_stage.sv
// Randomized and directed bench for vshift_operand_stage, checked every cycle against a
// queue-based FIFO model and a lane-by-lane arithmetic formatter.
module tb_vshift_operand_stage;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vshift_operand_stage_if #(.DATA_W(DW), .XLEN(64), .IMM_W(5)) bus ();

    vshift_operand_stage #(.DATA_W(DW), .XLEN(64), .IMM_W(5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic          err;
        logic [2:0]    vsew;
        logic [1:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } exp_t;

    exp_t q[$];
    bit   m_ready = 1'b1;
    bit   m_init  = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   txn     = 0;

    function automatic logic [DW-1:0] fmt(input logic [2:0] vsew, input logic [1:0] src,
                                          input logic [DW-1:0] vs1, input logic [63:0] rs1,
                                          input logic [4:0] imm);
        logic [DW-1:0]   res;
        longint unsigned amt;
        int              sew;
        res = '0;
        if (vsew > 3'd3 || src == 2'd3) return res;
        sew = 8 << vsew;
        for (int l = 0; l < DW / sew; l++) begin
            if (src == 2'd0) amt = 64'(vs1 >> (l * sew));
            else if (src == 2'd1) amt = rs1;
            else amt = 64'(imm);
            amt = amt % longint'(sew);
            res = res | (DW'(amt) << (l * sew));
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a FIFO of at most two entries; ready reflects room after the edge.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ready = 1'b1;
            m_init  = 1'b1;
        end else if (m_init) begin
            if (bus.flush_i) begin
                q.delete();
                m_ready = 1'b1;
            end else begin
                bit   push;
                bit   pop;
                exp_t e;
                push = bus.valid_i && m_ready;
                pop  = (q.size() > 0) && bus.ready_i;
                e.err  = (bus.vsew_i > 3'd3) || (bus.src_sel_i == 2'd3);
                e.vsew = bus.vsew_i;
                e.op   = bus.op_i;
                e.a    = bus.vs2_i;
                e.b    = fmt(bus.vsew_i, bus.src_sel_i, bus.vs1_i, bus.rs1_i, bus.imm_i);
                if (pop) begin
                    $display("txn %0d out: vsew=%0d op=%0d err=%0b a=%h b=%h", txn,
                             q[0].vsew, q[0].op, q[0].err, q[0].a, q[0].b);
                    txn++;
                    void'(q.pop_front());
                end
                if (push) q.push_back(e);
                m_ready = (q.size() < 2);
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("ready_o", DW'(bus.ready_o), DW'(m_ready));
            chk("valid_o", DW'(bus.valid_o), DW'(q.size() > 0));
            if (q.size() > 0) begin
                chk("a_o", bus.a_o, q[0].a);
                chk("b_o", bus.b_o, q[0].b);
                chk("vsew_o", DW'(bus.vsew_o), DW'(q[0].vsew));
                chk("op_o", DW'(bus.op_o), DW'(q[0].op));
                chk("err_o", DW'(bus.err_o), DW'(q[0].err));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] src, input logic [2:0] vsew, input logic [1:0] op,
                       input logic [DW-1:0] vs2, input logic [DW-1:0] vs1,
                       input logic [63:0] rs1, input logic [4:0] imm);
        bus.valid_i   = 1'b1;
        bus.src_sel_i = src;
        bus.vsew_i    = vsew;
        bus.op_i      = op;
        bus.vs2_i     = vs2;
        bus.vs1_i     = vs1;
        bus.rs1_i     = rs1;
        bus.imm_i     = imm;
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk_reset_values(input string tag);
        chk({tag, "_valid"}, DW'(bus.valid_o), '0);
        chk({tag, "_ready"}, DW'(bus.ready_o), DW'(1));
        chk({tag, "_err"}, DW'(bus.err_o), '0);
        chk({tag, "_vsew"}, DW'(bus.vsew_o), '0);
        chk({tag, "_op"}, DW'(bus.op_o), '0);
        chk({tag, "_a"}, bus.a_o, '0);
        chk({tag, "_b"}, bus.b_o, '0);
    endtask

    logic [DW-1:0] va, vb, vc, exp_v;

    initial begin
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b1;
        req(2'd0, 3'd0, 2'd0, '0, '0, '0, '0);
        bus.valid_i = 1'b0;

        // Pin the formatter model with hand-computed values
        exp_v = {16{8'h03}};
        chk("pin_vx8", fmt(3'd0, 2'd1, '0, 64'hFFFF_FFFF_FFFF_FF0B, 5'd0), exp_v);
        exp_v = {64'h1F, 64'h1F};
        chk("pin_vi64", fmt(3'd3, 2'd2, '0, '0, 5'h1F), exp_v);
        exp_v = {8{16'h0003}};
        chk("pin_vv16", fmt(3'd1, 2'd0, {8{16'h0013}}, '0, 5'd0), exp_v);
        chk("pin_illegal", fmt(3'd5, 2'd0, {8{16'h0013}}, '0, 5'd0), '0);

        step();
        chk_reset_values("rst");
        step();
        rst = 1'b0;

        // VX byte lanes
        va = rnd128();
        req(2'd1, 3'd0, 2'd2, va, rnd128(), 64'hFFFF_FFFF_FFFF_FF0B, 5'd0);
        step();
        bus.valid_i = 1'b0;
        chk("t1_valid", DW'(bus.valid_o), DW'(1));
        exp_v = {16{8'h03}};
        chk("t1_b", bus.b_o, exp_v);
        chk("t1_a", bus.a_o, va);
        step();

        // VI 64-bit and VV 16-bit
        req(2'd2, 3'd3, 2'd0, rnd128(), rnd128(), 64'd0, 5'h1F);
        step();
        exp_v = {64'h1F, 64'h1F};
        chk("t2_vi_b", bus.b_o, exp_v);
        req(2'd0, 3'd1, 2'd1, rnd128(), {8{16'h0013}}, 64'd0, 5'd0);
        step();
        bus.valid_i = 1'b0;
        exp_v = {8{16'h0003}};
        chk("t2_vv_b", bus.b_o, exp_v);
        step();

        // Back-to-back under backpressure, then drain with a push+pop in ONE
        bus.ready_i = 1'b0;
        va = 128'h1; vb = 128'h2; vc = 128'h3;
        req(2'd0, 3'd2, 2'd0, va, rnd128(), 64'd0, 5'd0);
        step();
        req(2'd0, 3'd2, 2'd0, vb, rnd128(), 64'd0, 5'd0);
        step();
        chk("t3_ready_full", DW'(bus.ready_o), '0);
        req(2'd0, 3'd2, 2'd0, vc, rnd128(), 64'd0, 5'd0);
        repeat (3) step();
        chk("t3_stall_a", bus.a_o, va);
        bus.ready_i = 1'b1;
        step();
        chk("t3_second", bus.a_o, vb);
        step();
        bus.valid_i = 1'b0;
        chk("t4_no_bubble_valid", DW'(bus.valid_o), DW'(1));
        chk("t4_third", bus.a_o, vc);
        step();
        chk("t4_drained", DW'(bus.valid_o), '0);

        // Illegal encodings, then a legal request clears err
        req(2'd3, 3'd0, 2'd0, rnd128(), rnd128(), 64'd7, 5'd3);
        step();
        chk("t5_err", DW'(bus.err_o), DW'(1));
        chk("t5_b_zero", bus.b_o, '0);
        req(2'd0, 3'd5, 2'd1, rnd128(), rnd128(), 64'd7, 5'd3);
        step();
        chk("t5_vsew_err", DW'(bus.err_o), DW'(1));
        chk("t5_vsew_pass", DW'(bus.vsew_o), DW'(5));
        req(2'd1, 3'd2, 2'd1, rnd128(), rnd128(), 64'd7, 5'd3);
        step();
        bus.valid_i = 1'b0;
        chk("t5_legal_err", DW'(bus.err_o), '0);
        step();

        // Flush a full buffer with a concurrent push
        bus.ready_i = 1'b0;
        req(2'd0, 3'd0, 2'd0, rnd128(), rnd128(), 64'd0, 5'd0);
        repeat (2) step();
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        chk("t6_flush_valid", DW'(bus.valid_o), '0);
        chk("t6_flush_ready", DW'(bus.ready_o), DW'(1));
        bus.ready_i = 1'b1;
        step();

        // Randomized traffic with occasional flush and a mid-stream reset
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] vs;
            logic [1:0] sr;
            int r;
            r  = $urandom_range(0, 9);
            vs = (r < 8) ? 3'(r % 4) : 3'($urandom_range(4, 7));
            sr = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            req(sr, vs, 2'($urandom_range(0, 3)), rnd128(), rnd128(),
                {$urandom, $urandom}, 5'($urandom_range(0, 31)));
            bus.valid_i = ($urandom_range(0, 3) != 0);
            bus.ready_i = ($urandom_range(0, 2) != 0);
            bus.flush_i = ($urandom_range(0, 49) == 0);
            if (i == 1500) rst = 1'b1;
            step();
            if (i == 1500) begin
                rst = 1'b0;
                chk_reset_values("mid_rst");
            end
        end
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b1;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
